// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes the 3-bit ALU_Control code and computes result, zero, overflow and illegal_op.
// Latency: an op accepted on edge N is presented on the outputs after edge N+1; one op per cycle sustained.
// Backpressure: holds up to two ops (S1 operands, S2 result); outputs stay stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   flush                 synchronous squash of both pipeline stages
//   in_valid / in_ready   input handshake for ALU_Control, operand_a, operand_b
//   out_valid / out_ready output handshake for result, zero, overflow, illegal_op
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALU_Control,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal_op
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;

    // Stage 1: registered operation and operands
    logic             s1_valid;
    logic [2:0]       s1_ctrl;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // Stage 2: registered result; its valid bit is out_valid
    logic             s2_valid;

    logic             s2_advance;
    logic             accept;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt_bit;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;

    assign s2_advance = s1_valid && (!s2_valid || out_ready);
    assign in_ready   = !flush && (!s1_valid || s2_advance);
    assign accept     = in_valid && in_ready;
    assign out_valid  = s2_valid;

    assign sum  = s1_a + s1_b;
    assign diff = s1_a - s1_b;
    // True signed compare rather than the sign of diff, so slt stays correct when a-b overflows.
    assign slt_bit = $signed(s1_a) < $signed(s1_b);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (s1_ctrl)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND:  alu_res = s1_a & s1_b;
            OP_OR:   alu_res = s1_a | s1_b;
            OP_XOR:  alu_res = s1_a ^ s1_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            default: alu_ill = 1'b1;   // 101 and 111: result 0, which also sets zero
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_ctrl    <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s2_valid   <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            illegal_op <= 1'b0;
        end else if (flush) begin
            // A handshake completing this cycle is still delivered; everything else is dropped.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            // S1 reloads when an accept coincides with its drain into S2.
            if (accept) begin
                s1_valid <= 1'b1;
                s1_ctrl  <= ALU_Control;
                s1_a     <= operand_a;
                s1_b     <= operand_b;
            end else if (s2_advance) begin
                s1_valid <= 1'b0;
            end

            // S2 reloads on a same-cycle output handshake, keeping out_valid high.
            if (s2_advance) begin
                s2_valid   <= 1'b1;
                result     <= alu_res;
                zero       <= (alu_res == '0);
                overflow   <= alu_ovf;
                illegal_op <= alu_ill;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 3-bit ALU_Control code produced by the ALU control decoder and computes the datapath result.
- Two-stage pipeline with valid/ready handshakes on both sides, so upstream decode and downstream memory/writeback can stall independently.
- A synchronous flush input squashes in-flight operations on branch redirect.

Parameters:
WIDTH, 32, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all in-flight operations
in_valid  input  1  operands and ALU_Control are valid this cycle
in_ready  output  1  unit accepts the input this cycle
ALU_Control  input  3  operation code (encoding below)
operand_a  input  WIDTH  first operand
operand_b  input  WIDTH  second operand
out_valid  output  1  result and flags are valid
out_ready  input  1  downstream accepts the result
result  output  WIDTH  operation result
zero  output  1  result == 0 (beq/bne use)
overflow  output  1  signed overflow (add/sub only)
illegal_op  output  1  ALU_Control was an unassigned code

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, result=0, zero=0, overflow=0, illegal_op=0. Reset mid-operation discards everything. First accept is possible on the first edge after release.
- Encoding:
  - 010 add: a+b mod 2^WIDTH
  - 110 sub: a-b mod 2^WIDTH
  - 000 and
  - 001 or
  - 011 xor
  - 100 slt: signed a<b gives result 1, else 0 (upper bits 0)
  - 101 and 111: illegal. result=0, zero=1, overflow=0, illegal_op=1.
- overflow:
  - add: operands have equal sign and the result sign differs.
  - sub: operand signs differ and the result sign differs from a.
  - slt uses the true signed comparison, not the sub sign bit, so no false result on overflow. overflow=0 for all non-add/sub ops.
- Stage 1 (S1) registers ALU_Control and the operands. Stage 2 (S2) registers result and flags, and drives all outputs directly from flops.
- Advance rules:
  - s2_advance = s1_valid && (!s2_valid || out_ready)
  - in_ready = !flush && (!s1_valid || s2_advance)
  - accept = in_valid && in_ready
- Latency: accept at edge N gives out_valid=1 after edge N+1, with no backpressure. Throughput is one op per cycle when out_ready=1.
- Backpressure: while out_valid && !out_ready, result and all flags hold stable. With both stages full and out_ready=0, in_ready=0. Two ops are buffered, with no loss and no duplication.
- Simultaneous events:
  - Output handshake and new S1→S2 transfer in the same cycle: S2 reloads, and out_valid stays 1.
  - Accept and S1 drain in the same cycle: S1 reloads.
- flush (highest priority after reset): at the next edge s1_valid=0 and s2_valid=0. in_ready=0 during the flush cycle, so no accept. A handshake completed in the flush cycle (out_valid&&out_ready) counts as delivered. result/flags data registers may keep stale values, but out_valid=0.
- ALU_Control and operands are don't-care when in_valid=0. No X may propagate into the valid flops.

Test Plan:
- Reset then single ops, out_ready=1:
  - add 0x00000005+0x00000003 → result 0x00000008, zero 0, overflow 0, out_valid exactly 2 edges after accept.
  - sub 7-7 → 0, zero 1.
- Overflow and slt:
  - add 0x7FFFFFFF+0x00000001 → 0x80000000, overflow 1.
  - sub 0x80000000-0x00000001 → 0x7FFFFFFF, overflow 1.
  - slt 0xFFFFFFFF,0x00000001 → 1.
  - slt 0x7FFFFFFF,0x80000000 → 0, overflow 0.
- Logic and illegal:
  - and/or/xor of 0xF0F0F0F0, 0xFF00FF00 → 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0.
  - codes 101 and 111 → result 0, zero 1, illegal_op 1.
- Backpressure:
  - Stream 5 adds with out_ready=0 for 4 cycles. in_ready drops after 2 accepts and outputs hold stable.
  - Release out_ready. All 5 results arrive in order, with no duplicates or drops.
- Flush: with both stages full, assert flush 1 cycle → out_valid=0 next cycle, and in_ready=0 during the flush cycle. A following accepted op emerges 2 edges later.
- Async reset mid-stream: drop rst_n between edges with out_valid=1 → out_valid and flags go 0 immediately, without waiting for a clock edge.
